matrix_stream_reader: RTL and testbench
=======================================

Name: matrix_stream_reader

Overview:
- Read-side client of the storage access path; drives the display read address into the storage mux.
- Walks one stored matrix element by element and absorbs the storage's 1-cycle synchronous read latency.
- Streams elements to the display/UART formatter over a valid/ready handshake, with row-end and last markers.
- Used in the display and result-output states; never writes storage.

Parameters:
- ADDR_W, 8, storage address width
- DATA_W, 32, element width
- DIM_W, 3, width of row/column count inputs
- MAX_DIM, 5, largest legal row or column count

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle request to begin a readout; honoured only in IDLE
- i_base  in  ADDR_W  storage address of element (0,0)
- i_rows  in  DIM_W  number of rows
- i_cols  in  DIM_W  number of columns
- o_rd_addr  out  ADDR_W  read address to the storage mux (display channel)
- i_rd_data  in  DATA_W  storage read data, valid 1 cycle after the address
- o_elem_data  out  DATA_W  current element
- o_elem_valid  out  1  element valid
- i_elem_ready  in  1  consumer accepts the element
- o_row_end  out  1  qualifies o_elem_valid: last element of a row (or column, in transpose mode)
- o_last  out  1  qualifies o_elem_valid: final element of the matrix
- o_busy  out  1  high whenever the FSM is not in IDLE
- o_done  out  1  one-cycle pulse at the end of a readout
- o_err  out  1  one-cycle pulse, coincident with o_done, on an illegal request

Behaviour:
- Reset: asynchronous, active-high. FSM goes to IDLE. All outputs are 0; o_rd_addr = 0 and o_elem_data = 0.
- States: IDLE, RD, CAP, SEND, DONE.
- Start (cycle t, IDLE, i_start = 1):
  - Latch i_base, i_rows and i_cols; clear row and column counters.
  - If rows = 0, cols = 0, rows > MAX_DIM or cols > MAX_DIM, go to DONE. o_err = 1 only for the > MAX_DIM cases. No reads are issued.
  - Otherwise go to RD.
- i_start outside IDLE is ignored. Inputs are not re-sampled mid-readout.
- RD: o_rd_addr = base + r*cols + c, computed modulo 2^ADDR_W (wraps at 255 -> 0). Next state is CAP.
- CAP: capture i_rd_data into o_elem_data. Compute o_row_end (c == cols-1) and o_last (r == rows-1 and c == cols-1). Next state is SEND.
- SEND:
  - o_elem_valid = 1. Data, o_row_end and o_last are held stable until i_elem_ready = 1.
  - On handshake: if last, go to DONE. Otherwise advance c (wrapping to 0 and incrementing r) and go to RD.
- DONE: o_done = 1 for exactly one cycle, then IDLE.
- o_rd_addr keeps its last value outside RD (glitch-free for the mux).
- Timing with i_elem_ready held high:
  - first o_elem_valid at t+3; element k valid at t+3+3k;
  - o_done at t+3N+1 for N elements.
- Backpressure only stretches SEND. No element is dropped or duplicated.
- o_busy = 1 from t+1 through the DONE cycle inclusive.
- Reset mid-readout aborts immediately. No o_done is produced.

Optional Feature:
- Macro: MATRIX_READER_TRANSPOSE_EN.
- Defined:
  - extra input i_transpose, latched at start;
  - when set, traversal is column-major: the row index is the inner loop and the address is still base + r*cols + c;
  - o_row_end marks r == rows-1.
- Undefined: port absent; row-major only.

Test Plan:
- base=0x10, rows=2, cols=3, ready=1, storage holds addr+0x100:
  - addresses 0x10..0x15 in order;
  - data 0x110..0x115;
  - o_row_end on the 3rd and 6th elements, o_last on the 6th;
  - o_done at t+19.
- Same request, ready low for 4 cycles on element 2: o_elem_data = 0x111 held stable with valid high; total 6 transfers; o_done delayed by 4 cycles.
- rows=0, cols=3: no RD state; o_done at t+1; o_err = 0; o_busy high for 1 cycle.
- rows=6, cols=1: o_done and o_err pulse together at t+1; o_rd_addr unchanged.
- base=0xFE, rows=1, cols=4: addresses 0xFE, 0xFF, 0x00, 0x01. i_start pulsed again mid-readout is ignored.
- With MATRIX_READER_TRANSPOSE_EN, 2x3 at base 0x10, transpose=1: addresses 0x10, 0x13, 0x11, 0x14, 0x12, 0x15; o_row_end on every 2nd element.
- Reset asserted in SEND: outputs 0 asynchronously; the next i_start runs a clean readout.

Source files
------------

// File: rtl/matrix_stream_reader.sv
// matrix_stream_reader
// Read-side client of the matrix storage. Walks one stored matrix element by
// element, drives the display-channel read address, absorbs the storage's
// one-cycle read latency and streams each element over valid/ready with
// row-end and last markers. Never writes storage.
//
// Optional build macro MATRIX_READER_TRANSPOSE_EN adds i_transpose, which
// selects column-major traversal (row index as the inner loop). Without the
// macro the reader is row-major only.
//
// Handshake: o_elem_valid rises in SEND and stays high, with o_elem_data,
// o_row_end and o_last held stable, until a cycle in which i_elem_ready is
// also high; that rising edge is the transfer. Valid never drops without a
// transfer except on reset.
module matrix_stream_reader #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int DIM_W   = 3,
  parameter int MAX_DIM = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [DIM_W-1:0]  i_rows,
  input  logic [DIM_W-1:0]  i_cols,
`ifdef MATRIX_READER_TRANSPOSE_EN
  input  logic              i_transpose,
`endif
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_elem_data,
  output logic              o_elem_valid,
  input  logic              i_elem_ready,
  output logic              o_row_end,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CAP  = 3'd2,
    S_SEND = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [DIM_W-1:0] C_MAX = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] C_ONE = DIM_W'(1);

  state_t              r_state;
  state_t              w_next_state;

  logic [ADDR_W-1:0]   r_base;
  logic [DIM_W-1:0]    r_rows;
  logic [DIM_W-1:0]    r_cols;
  logic [DIM_W-1:0]    r_r;
  logic [DIM_W-1:0]    r_c;
  logic                r_err;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [DATA_W-1:0]   r_elem_data;
  logic                r_row_end;
  logic                r_last;

  logic                w_col_major;
  logic                w_accept;
  logic                w_zero;
  logic                w_oversize;
  logic                w_req_ok;
  logic                w_r_at_end;
  logic                w_c_at_end;
  logic                w_handshake;
  logic                w_advance;
  logic [DIM_W-1:0]    w_next_r;
  logic [DIM_W-1:0]    w_next_c;
  logic [2*DIM_W-1:0]  w_prod;
  logic [ADDR_W-1:0]   w_next_addr;

`ifdef MATRIX_READER_TRANSPOSE_EN
  logic                r_transpose;

  // Traversal order is latched with the request so it cannot change mid-walk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_transpose <= 1'b0;
    end else if (w_accept) begin
      r_transpose <= i_transpose;
    end
  end

  assign w_col_major = r_transpose;
`else
  assign w_col_major = 1'b0;
`endif

  // Request qualification; empty matrices finish quietly, oversize ones flag an error
  assign w_accept    = (r_state == S_IDLE) && i_start;
  assign w_zero      = (i_rows == '0) || (i_cols == '0);
  assign w_oversize  = (i_rows > C_MAX) || (i_cols > C_MAX);
  assign w_req_ok    = !w_zero && !w_oversize;

  assign w_r_at_end  = (r_r == (r_rows - C_ONE));
  assign w_c_at_end  = (r_c == (r_cols - C_ONE));
  assign w_handshake = (r_state == S_SEND) && i_elem_ready;
  assign w_advance   = w_handshake && !r_last;

  // Next element indices: inner loop is the column (row-major) or the row (column-major)
  always_comb begin
    w_next_r = r_r;
    w_next_c = r_c;
    if (w_col_major) begin
      if (w_r_at_end) begin
        w_next_r = '0;
        w_next_c = r_c + C_ONE;
      end else begin
        w_next_r = r_r + C_ONE;
      end
    end else begin
      if (w_c_at_end) begin
        w_next_c = '0;
        w_next_r = r_r + C_ONE;
      end else begin
        w_next_c = r_c + C_ONE;
      end
    end
  end

  // Linear address of the next element; the sum wraps modulo 2^ADDR_W
  assign w_prod      = {{DIM_W{1'b0}}, w_next_r} * {{DIM_W{1'b0}}, r_cols};
  assign w_next_addr = r_base + ADDR_W'(w_prod) + ADDR_W'(w_next_c);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next_state = w_req_ok ? S_RD : S_DONE;
        end
      end
      S_RD:   w_next_state = S_CAP;
      S_CAP:  w_next_state = S_SEND;
      S_SEND: begin
        if (i_elem_ready) begin
          w_next_state = r_last ? S_DONE : S_RD;
        end
      end
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs; markers are only meaningful alongside valid so they are gated by SEND
  always_comb begin
    o_elem_valid = 1'b0;
    o_row_end    = 1'b0;
    o_last       = 1'b0;
    o_busy       = 1'b1;
    o_done       = 1'b0;
    o_err        = 1'b0;
    case (r_state)
      S_IDLE: o_busy = 1'b0;
      S_SEND: begin
        o_elem_valid = 1'b1;
        o_row_end    = r_row_end;
        o_last       = r_last;
      end
      S_DONE: begin
        o_done = 1'b1;
        o_err  = r_err;
      end
      default: ;
    endcase
  end

  // Latch the request; geometry and base stay frozen until the next accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base <= '0;
      r_rows <= '0;
      r_cols <= '0;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_base <= i_base;
      r_rows <= i_rows;
      r_cols <= i_cols;
      r_err  <= w_oversize;
    end
  end

  // Element indices: cleared at start, stepped once per accepted non-final transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_r <= '0;
      r_c <= '0;
    end else if (w_accept) begin
      r_r <= '0;
      r_c <= '0;
    end else if (w_advance) begin
      r_r <= w_next_r;
      r_c <= w_next_c;
    end
  end

  // Read address is loaded on entry to RD and held otherwise so the mux sees no glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_addr <= '0;
    end else if (w_accept && w_req_ok) begin
      r_rd_addr <= i_base;
    end else if (w_advance) begin
      r_rd_addr <= w_next_addr;
    end
  end

  // Capture storage data one cycle after the address, together with its markers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_elem_data <= '0;
      r_row_end   <= 1'b0;
      r_last      <= 1'b0;
    end else if (r_state == S_CAP) begin
      r_elem_data <= i_rd_data;
      r_row_end   <= w_col_major ? w_r_at_end : w_c_at_end;
      r_last      <= w_r_at_end && w_c_at_end;
    end
  end

  assign o_rd_addr   = r_rd_addr;
  assign o_elem_data = r_elem_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_matrix_stream_reader.sv
// Directed testbench for matrix_stream_reader with a behavioural
// one-cycle-latency storage that returns address + 0x100.
module tb_matrix_stream_reader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DIM_W  = 3;
  localparam logic [2:0] ST_RD = 3'd1;

  logic              clk;
  logic              rst;
  logic              i_start;
  logic [ADDR_W-1:0] i_base;
  logic [DIM_W-1:0]  i_rows;
  logic [DIM_W-1:0]  i_cols;
`ifdef MATRIX_READER_TRANSPOSE_EN
  logic              i_transpose;
`endif
  logic [ADDR_W-1:0] o_rd_addr;
  logic [DATA_W-1:0] i_rd_data;
  logic [DATA_W-1:0] o_elem_data;
  logic              o_elem_valid;
  logic              i_elem_ready;
  logic              o_row_end;
  logic              o_last;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  logic [2:0]        o_dbg_state;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [1:0]        exp_flag_q[$];

  matrix_stream_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W), .MAX_DIM(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_start(i_start),
    .i_base(i_base),
    .i_rows(i_rows),
    .i_cols(i_cols),
`ifdef MATRIX_READER_TRANSPOSE_EN
    .i_transpose(i_transpose),
`endif
    .o_rd_addr(o_rd_addr),
    .i_rd_data(i_rd_data),
    .o_elem_data(o_elem_data),
    .o_elem_valid(o_elem_valid),
    .i_elem_ready(i_elem_ready),
    .o_row_end(o_row_end),
    .o_last(o_last),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_err(o_err),
    .o_dbg_state(o_dbg_state)
  );

  // Clock and storage model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    i_rd_data <= DATA_W'(o_rd_addr) + 32'h100;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic re, input logic last);
    exp_addr_q.push_back(a);
    exp_q.push_back(DATA_W'(a) + 32'h100);
    exp_flag_q.push_back({re, last});
  endtask

  task automatic clear_q();
    exp_addr_q.delete();
    exp_q.delete();
    exp_flag_q.delete();
  endtask

  // Presents a start request; it is sampled on the next rising edge (cycle t)
  task automatic start_req(input logic [ADDR_W-1:0] base, input logic [DIM_W-1:0] rows,
                           input logic [DIM_W-1:0] cols, input logic tr);
    @(negedge clk);
    i_start = 1'b1;
    i_base  = base;
    i_rows  = rows;
    i_cols  = cols;
`ifdef MATRIX_READER_TRANSPOSE_EN
    i_transpose = tr;
`else
    if (tr) $display("transpose request ignored in this build");
`endif
  endtask

  // Runs one readout, checking every address, transfer and busy cycle; cycle 1 is t+1
  task automatic run(input int stall_idx, input int stall_len, input int restart_cyc,
                     input int budget, output int done_cyc, output logic err_seen);
    int cyc;
    int elem;
    int stall;
    logic [1:0] fl;
    cyc = 0;
    elem = 0;
    stall = 0;
    done_cyc = -1;
    err_seen = 1'b0;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) i_start = 1'b0;
      if (restart_cyc > 0 && cyc == restart_cyc) begin
        i_start = 1'b1;
        i_base  = 8'h40;
        i_rows  = 3'd1;
        i_cols  = 3'd1;
      end else if (restart_cyc > 0 && cyc == restart_cyc + 1) begin
        i_start = 1'b0;
      end
      check("busy", {31'b0, o_busy}, 32'd1);
      if (o_dbg_state == ST_RD) begin
        if (exp_addr_q.size() == 0) check("extra_rd", 32'd1, 32'd0);
        else check("rd_addr", {24'b0, o_rd_addr}, {24'b0, exp_addr_q.pop_front()});
      end
      if (o_elem_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_elem", 32'd1, 32'd0);
          i_elem_ready = 1'b1;
        end else if (elem == stall_idx && stall < stall_len) begin
          i_elem_ready = 1'b0;
          stall++;
          check("held_data", o_elem_data, exp_q[0]);
        end else begin
          i_elem_ready = 1'b1;
          fl = exp_flag_q.pop_front();
          check("elem_data", o_elem_data, exp_q.pop_front());
          check("row_end", {31'b0, o_row_end}, {31'b0, fl[1]});
          check("last", {31'b0, o_last}, {31'b0, fl[0]});
          elem++;
        end
      end else begin
        i_elem_ready = 1'b1;
      end
      if (o_done) begin
        done_cyc = cyc;
        err_seen = o_err;
        break;
      end
    end
    if (done_cyc < 0) check("done_timeout", 32'd1, 32'd0);
    check("elems_left", exp_q.size(), 32'd0);
    check("addrs_left", exp_addr_q.size(), 32'd0);
    @(negedge clk);
    check("busy_after", {31'b0, o_busy}, 32'd0);
    check("done_after", {31'b0, o_done}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'b0, o_elem_valid}, 32'd0);
    check({tag, "_data"}, o_elem_data, 32'd0);
    check({tag, "_addr"}, {24'b0, o_rd_addr}, 32'd0);
    check({tag, "_busy"}, {31'b0, o_busy}, 32'd0);
    check({tag, "_done"}, {31'b0, o_done}, 32'd0);
    check({tag, "_err"}, {31'b0, o_err}, 32'd0);
    check({tag, "_flags"}, {30'b0, o_row_end, o_last}, 32'd0);
  endtask

  initial begin
    int dc;
    logic es;
    int w;
    rst = 1'b1;
    i_start = 1'b0;
    i_base = '0;
    i_rows = '0;
    i_cols = '0;
    i_elem_ready = 1'b1;
`ifdef MATRIX_READER_TRANSPOSE_EN
    i_transpose = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // 2x3 at 0x10, ready always high
    clear_q();
    push(8'h10, 0, 0); push(8'h11, 0, 0); push(8'h12, 1, 0);
    push(8'h13, 0, 0); push(8'h14, 0, 0); push(8'h15, 1, 1);
    start_req(8'h10, 3'd2, 3'd3, 1'b0);
    run(-1, 0, 0, 60, dc, es);
    check("t1_done_cyc", dc, 32'd19);
    check("t1_err", {31'b0, es}, 32'd0);

    // same request, element index 1 stalled 4 cycles
    clear_q();
    push(8'h10, 0, 0); push(8'h11, 0, 0); push(8'h12, 1, 0);
    push(8'h13, 0, 0); push(8'h14, 0, 0); push(8'h15, 1, 1);
    start_req(8'h10, 3'd2, 3'd3, 1'b0);
    run(1, 4, 0, 60, dc, es);
    check("t2_done_cyc", dc, 32'd23);

    // rows = 0: finishes immediately without error
    clear_q();
    start_req(8'h30, 3'd0, 3'd3, 1'b0);
    run(-1, 0, 0, 10, dc, es);
    check("t3_done_cyc", dc, 32'd1);
    check("t3_err", {31'b0, es}, 32'd0);
    check("t3_addr_kept", {24'b0, o_rd_addr}, 32'h15);

    // rows = 6: error pulse with done
    clear_q();
    start_req(8'h30, 3'd6, 3'd1, 1'b0);
    run(-1, 0, 0, 10, dc, es);
    check("t4_done_cyc", dc, 32'd1);
    check("t4_err", {31'b0, es}, 32'd1);
    check("t4_addr_kept", {24'b0, o_rd_addr}, 32'h15);

    // address wrap, with a start pulse mid-readout that must be ignored
    clear_q();
    push(8'hFE, 0, 0); push(8'hFF, 0, 0); push(8'h00, 0, 0); push(8'h01, 1, 1);
    start_req(8'hFE, 3'd1, 3'd4, 1'b0);
    run(-1, 0, 4, 60, dc, es);
    check("t5_done_cyc", dc, 32'd13);
    check("t5_err", {31'b0, es}, 32'd0);

`ifdef MATRIX_READER_TRANSPOSE_EN
    // column-major walk of 2x3 at 0x10
    clear_q();
    push(8'h10, 0, 0); push(8'h13, 1, 0); push(8'h11, 0, 0);
    push(8'h14, 1, 0); push(8'h12, 0, 0); push(8'h15, 1, 1);
    start_req(8'h10, 3'd2, 3'd3, 1'b1);
    run(-1, 0, 0, 60, dc, es);
    check("tr_done_cyc", dc, 32'd19);
    i_transpose = 1'b0;
`endif

    // reset asserted while an element is being offered
    clear_q();
    start_req(8'h10, 3'd2, 3'd3, 1'b0);
    @(negedge clk);
    i_start = 1'b0;
    w = 0;
    while (!o_elem_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("rst_reached_send", {31'b0, o_elem_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;

    // clean readout after the abort
    clear_q();
    push(8'h20, 0, 0); push(8'h21, 1, 1);
    start_req(8'h20, 3'd1, 3'd2, 1'b0);
    run(-1, 0, 0, 30, dc, es);
    check("t7_done_cyc", dc, 32'd7);
    check("t7_err", {31'b0, es}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
